// File: rtl/mem_pkg.sv
// Shared types and sizes for the 8x8 register-file memory and its host-side controller.
// MEM_CTRL_INIT_CLEAR_EN adds the INIT state used by the power-on clear sweep.
package mem_pkg;

  localparam int unsigned MEM_DW    = 8;
  localparam int unsigned MEM_AW    = 3;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RESP = 3'd3
`ifdef MEM_CTRL_INIT_CLEAR_EN
    , ST_INIT = 3'd4
`endif
  } mem_ctrl_state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Host-side initiator for the negedge-sampling register-file memory: one request in flight,
// registered memory port, posted writes, valid/ready read response. MEM_CTRL_INIT_CLEAR_EN enables the clear sweep.
module mem_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [MEM_DW-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [MEM_DW-1:0] resp_rdata,
  output logic              mem_op,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_data_in,
  input  logic [MEM_DW-1:0] mem_data_out,
  output logic              init_busy
);

  localparam int unsigned DW = MEM_DW;
  localparam int unsigned AW = MEM_AW;

  mem_ctrl_state_e state_q, state_d;
  mem_op_e         mem_op_q, mem_op_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_in_q, mem_data_in_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            req_ready_q, req_ready_d;

`ifdef MEM_CTRL_INIT_CLEAR_EN
  localparam int unsigned CW = AW + 1;
  logic [CW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          init_busy_q, init_busy_d;
`endif

  // Next-state and next-output logic; every memory-side output is registered below.
  always_comb begin
    state_d       = state_q;
    mem_op_d      = OP_READ;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    resp_rdata_d  = resp_rdata_q;
    resp_valid_d  = 1'b0;
    req_ready_d   = 1'b0;
`ifdef MEM_CTRL_INIT_CLEAR_EN
    sweep_cnt_d   = sweep_cnt_q;
    init_busy_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr;
          if (req_write) begin
            mem_op_d      = OP_WRITE;
            mem_data_in_d = req_wdata;
            state_d       = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD: begin
        // Memory refreshed data_out at the mid-cycle negedge.
        resp_rdata_d = mem_data_out;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
`ifdef MEM_CTRL_INIT_CLEAR_EN
      ST_INIT: begin
        if (sweep_cnt_q == CW'(MEM_DEPTH)) begin
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          mem_op_d      = OP_WRITE;
          mem_addr_d    = sweep_cnt_q[AW-1:0];
          mem_data_in_d = '0;
          init_busy_d   = 1'b1;
          sweep_cnt_d   = sweep_cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef MEM_CTRL_INIT_CLEAR_EN
      state_q       <= ST_INIT;
      sweep_cnt_q   <= '0;
      init_busy_q   <= 1'b0;
`else
      state_q       <= ST_IDLE;
`endif
      mem_op_q      <= OP_READ;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      resp_rdata_q  <= '0;
      resp_valid_q  <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
`ifdef MEM_CTRL_INIT_CLEAR_EN
      sweep_cnt_q   <= sweep_cnt_d;
      init_busy_q   <= init_busy_d;
`endif
      state_q       <= state_d;
      mem_op_q      <= mem_op_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_valid_q  <= resp_valid_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign mem_op      = mem_op_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_valid  = resp_valid_q;
  assign req_ready   = req_ready_q;

`ifdef MEM_CTRL_INIT_CLEAR_EN
  assign init_busy = init_busy_q;
`else
  assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl with a negedge-sampling register-file memory alongside; results are
// checked against a plain array of expected contents and the request/response timing rules.
`timescale 1ns/1ps
module tb_mem_ctrl;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [MEM_AW-1:0] req_addr = '0;
  logic [MEM_DW-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [MEM_DW-1:0] resp_rdata;
  logic              mem_op;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_data_in;
  logic [MEM_DW-1:0] mem_data_out;
  logic              init_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [MEM_DW-1:0] ref_mem [MEM_DEPTH];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .init_busy    (init_busy)
  );

  // Register-file memory: samples op/addr/data_in and updates data_out on the negedge.
  logic [MEM_DW-1:0] mem_arr [MEM_DEPTH];
  bit mem_seeded = 1'b0;
  always @(negedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_arr[i] <= '0;
      mem_seeded <= 1'b1;
    end else begin
      if (mem_op) mem_arr[mem_addr] <= mem_data_in;
      mem_data_out <= mem_arr[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_op", 32'(mem_op), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
`ifdef MEM_CTRL_INIT_CLEAR_EN
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      check("init_busy", 32'(init_busy), 32'd1);
      check("init_mem_op", 32'(mem_op), 32'd1);
      check("init_mem_addr", 32'(mem_addr), 32'(i));
      check("init_mem_data_in", 32'(mem_data_in), 32'd0);
      check("init_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    check("init_done_busy", 32'(init_busy), 32'd0);
    check("init_done_mem_op", 32'(mem_op), 32'd0);
    for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = '0;
`else
    check("boot_init_busy", 32'(init_busy), 32'd0);
    check("boot_mem_op", 32'(mem_op), 32'd0);
`endif
    check("boot_req_ready", 32'(req_ready), 32'd1);
    check("boot_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_write(input logic [MEM_AW-1:0] a, input logic [MEM_DW-1:0] d);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
    check("wr_mem_op", 32'(mem_op), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'(a));
    check("wr_mem_data_in", 32'(mem_data_in), 32'(d));
    check("wr_req_ready", 32'(req_ready), 32'd0);
    step();
    check("wr_done_mem_op", 32'(mem_op), 32'd0);
    check("wr_done_req_ready", 32'(req_ready), 32'd1);
    check("wr_no_resp", 32'(resp_valid), 32'd0);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [MEM_AW-1:0] a, input int hold);
    wait_ready();
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = a;
    req_wdata  = 8'($urandom);
    resp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    check("rd_req_ready", 32'(req_ready), 32'd0);
    check("rd_mem_op", 32'(mem_op), 32'd0);
    check("rd_mem_addr", 32'(mem_addr), 32'(a));
    check("rd_resp_early", 32'(resp_valid), 32'd0);
    step();
    check("rd_resp_valid", 32'(resp_valid), 32'd1);
    check("rd_resp_rdata", 32'(resp_rdata), 32'(ref_mem[a]));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr  = 3'($urandom);
      req_wdata = 8'($urandom);
      step();
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_resp_rdata", 32'(resp_rdata), 32'(ref_mem[a]));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_mem_op", 32'(mem_op), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    check("rd_done_resp_valid", 32'(resp_valid), 32'd0);
    check("rd_done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = '0;
    #1;
    do_reset();

    // Single write then read back.
    do_write(3'd3, 8'hA5);
    do_read(3'd3, 0);

    // Fill every address, then read all in order.
    for (int i = 0; i < int'(MEM_DEPTH); i++) do_write(3'(i), 8'(8'h10 + i));
    for (int i = 0; i < int'(MEM_DEPTH); i++) do_read(3'(i), 0);

    // Response back-pressure with competing requests ignored.
    do_read(3'd5, 5);
    do_read(3'd3, 0);

    // Back-to-back writes with req_valid held high.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr  = 3'(7 - k);
      req_wdata = 8'(8'hC0 + k);
      check("b2b_ready_hi", 32'(req_ready), 32'd1);
      check("b2b_op_lo", 32'(mem_op), 32'd0);
      step();
      check("b2b_ready_lo", 32'(req_ready), 32'd0);
      check("b2b_op_hi", 32'(mem_op), 32'd1);
      check("b2b_addr", 32'(mem_addr), 32'(7 - k));
      check("b2b_data", 32'(mem_data_in), 32'(8'hC0 + k));
      ref_mem[7 - k] = 8'(8'hC0 + k);
      step();
    end
    req_valid = 1'b0;
    for (int i = 4; i < 8; i++) do_read(3'(i), 1);

    // Reset while a response is waiting.
    wait_ready();
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 3'd6;
    resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    check("resp_before_rst", 32'(resp_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale_resp", 32'(resp_valid), 32'd0);
      check("idle_after_rst", 32'(req_ready), 32'd1);
    end
    do_read(3'd6, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(3'($urandom), 8'($urandom));
      else do_read(3'($urandom), int'($urandom_range(0, 3)));
    end

    // Preload all ones, pulse reset, read everything back.
    for (int i = 0; i < int'(MEM_DEPTH); i++) do_write(3'(i), 8'hFF);
    do_reset();
    for (int i = 0; i < int'(MEM_DEPTH); i++) do_read(3'(i), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
